pc_run_ctrl: RTL and testbench

//  Run/pause/single-step sequencer for the program counter. Sits beside the PC register.

---
 rtl/pc_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pc_run_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl -- run/pause/single-step sequencer for the program counter.
//
// Produces the PC update enable and the wrap-to-zero load for the PC register
// beside it. The pause switch and the step button are synchronised (2 FF); the
// step button is also debounced, and each accepted press produces one step
// pulse. Retired PC updates are counted for the board display.
//
// Optional feature: define PC_BRKPT_EN to add the PC breakpoint (bp_addr,
// bp_valid ports and the BREAK state). Without it the ports do not exist, no
// breakpoint ever hits, and state 2'b11 is decoded as RUN.
//
// Parameters:
//   DB_CYCLES  consecutive differing synced samples before the button level flips
//   WRAP_ADDR  npc value at which the PC loads 0 instead of npc
//   CNT_W      width of retire_cnt
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   sw_i       board switches; sw_i[1] = pause, other bits ignored
//   step_btn   raw single-step pushbutton (bouncy, asynchronous)
//   pc, npc    current PC and next PC
//   bp_addr    breakpoint address (PC_BRKPT_EN only)
//   bp_valid   breakpoint armed (PC_BRKPT_EN only)
//   pc_we      PC register loads this cycle
//   pc_wrap    with pc_we: PC loads 0 instead of npc
//   halted     state is PAUSE or BREAK
//   run_state  00 RUN, 01 PAUSE, 10 STEP, 11 BREAK
//   retire_cnt number of cycles with pc_we = 1 (wraps)

module pc_run_ctrl #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter logic [31:0] WRAP_ADDR = 32'h48,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sw_i,
    input  logic             step_btn,
    input  logic [31:0]      pc,
    input  logic [31:0]      npc,
`ifdef PC_BRKPT_EN
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
`endif
    output logic             pc_we,
    output logic             pc_wrap,
    output logic             halted,
    output logic [1:0]       run_state,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StPause = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } run_state_e;

    // Synchronisers
    logic pause_meta_q, pause_sync_q;
    logic step_meta_q, step_sync_q;

    // Debouncer
    logic           step_level_q, step_level_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           step_pulse_q, step_pulse_d;

    // Sequencer
    run_state_e       state_q, state_d, cur_st;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             bp_hit;

`ifdef PC_BRKPT_EN
    assign cur_st = state_q;
    assign bp_hit = (cur_st == StRun) & bp_valid & (pc == bp_addr);

    logic unused_sw;
    assign unused_sw = ^{sw_i[15:2], sw_i[0]};
`else
    // BREAK cannot be entered without the breakpoint; treat it as RUN.
    assign cur_st = (state_q == StBreak) ? StRun : state_q;
    assign bp_hit = 1'b0;

    logic unused_in;
    assign unused_in = ^{sw_i[15:2], sw_i[0], pc};
`endif

    // The accepted level flips only after DB_CYCLES consecutive cycles of
    // disagreement; any agreeing sample restarts the count.
    always_comb begin
        step_level_d = step_level_q;
        db_cnt_d     = db_cnt_q;
        step_pulse_d = 1'b0;
        if (step_sync_q == step_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            step_level_d = step_sync_q;
            db_cnt_d     = '0;
            step_pulse_d = step_sync_q;  // only a 0->1 flip is a press
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
    end

    // Next state. A step pulse outside PAUSE/BREAK is simply dropped.
    always_comb begin
        state_d = cur_st;
        unique case (cur_st)
            StRun: begin
                if (bp_hit)            state_d = StBreak;
                else if (pause_sync_q) state_d = StPause;
                else                   state_d = StRun;
            end
            StPause: begin
                if (!pause_sync_q)     state_d = StRun;  // releasing pause beats a step
                else if (step_pulse_q) state_d = StStep;
                else                   state_d = StPause;
            end
            StStep: state_d = StPause;
            StBreak: begin
`ifdef PC_BRKPT_EN
                state_d = step_pulse_q ? StStep : StBreak;
`else
                state_d = StRun;
`endif
            end
            default: state_d = StRun;
        endcase
    end

    // The hit cycle masks pc_we so the PC holds at the breakpoint address.
    assign pc_we     = ~rst & (((cur_st == StRun) & ~bp_hit) | (cur_st == StStep));
    assign pc_wrap   = pc_we & (npc == WRAP_ADDR);
    assign halted    = (cur_st == StPause) | (cur_st == StBreak);
    assign run_state = cur_st;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pc_we) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_meta_q <= 1'b0;
            pause_sync_q <= 1'b0;
            step_meta_q  <= 1'b0;
            step_sync_q  <= 1'b0;
            step_level_q <= 1'b0;
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
            state_q      <= StRun;
            retire_cnt_q <= '0;
        end else begin
            pause_meta_q <= sw_i[1];
            pause_sync_q <= pause_meta_q;
            step_meta_q  <= step_btn;
            step_sync_q  <= step_meta_q;
            step_level_q <= step_level_d;
            db_cnt_q     <= db_cnt_d;
            step_pulse_q <= step_pulse_d;
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Scoreboard bench for pc_run_ctrl. A driver applies stimulus just after each
// rising edge, advances a behavioural model of the sequencer and pushes the
// expected outputs for the cycle; a monitor pops and compares on the falling
// edge. The bench also plays the role of the PC register (pc <= wrap ? 0 : npc,
// npc = pc + 4), using the model's own expectation of pc_we.

module tb_pc_run_ctrl;

    localparam int unsigned DB   = 4;
    localparam logic [31:0] WRAP = 32'h48;
    localparam int          CW   = 8;

    logic          clk;
    logic          rst;
    logic [15:0]   sw_i;
    logic          step_btn;
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic [31:0]   bp_addr;
    logic          bp_valid;
    logic          pc_we;
    logic          pc_wrap;
    logic          halted;
    logic [1:0]    run_state;
    logic [CW-1:0] retire_cnt;

`ifdef PC_BRKPT_EN
    localparam bit HasBp = 1'b1;
`else
    localparam bit HasBp = 1'b0;
`endif

    pc_run_ctrl #(
        .DB_CYCLES(DB),
        .WRAP_ADDR(WRAP),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_i      (sw_i),
        .step_btn  (step_btn),
        .pc        (pc),
        .npc       (npc),
`ifdef PC_BRKPT_EN
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
`endif
        .pc_we     (pc_we),
        .pc_wrap   (pc_wrap),
        .halted    (halted),
        .run_state (run_state),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic          wrap;
        logic          halted;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- reference model ----------------
    // States: 0 RUN, 1 PAUSE, 2 STEP, 3 BREAK
    int          m_st;
    bit          m_pause_hist[$];  // last two edge samples of sw_i[1], oldest first
    bit          m_btn_hist[$];
    bit          m_level;          // accepted button level
    int          m_run;            // consecutive cycles synced level != accepted
    bit          m_pulse;          // press accepted at the previous edge
    int          m_cnt;
    logic [31:0] m_pc;
    bit          rst_fired;

    task automatic model_reset();
        m_st = 0;
        m_pause_hist.delete();
        m_btn_hist.delete();
        m_level = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        m_cnt   = 0;
        m_pc    = 32'h0;
    endtask

    function automatic bit model_hit();
        return HasBp && (m_st == 0) && bp_valid && (m_pc == bp_addr);
    endfunction

    function automatic bit model_we();
        if (rst) return 1'b0;
        return ((m_st == 0) && !model_hit()) || (m_st == 2);
    endfunction

    // Called at a rising edge with the inputs that were held across it.
    task automatic model_edge();
        bit sp, sbtn, pulse, we, hit;
        int nst;
        if (rst) begin
            model_reset();
            return;
        end
        hit   = model_hit();
        we    = model_we();
        sp    = (m_pause_hist.size() == 2) ? m_pause_hist[0] : 1'b0;
        sbtn  = (m_btn_hist.size() == 2) ? m_btn_hist[0] : 1'b0;
        pulse = m_pulse;
        case (m_st)
            0:       nst = hit ? 3 : (sp ? 1 : 0);
            1:       nst = !sp ? 0 : (pulse ? 2 : 1);
            2:       nst = 1;
            default: nst = pulse ? 2 : 3;
        endcase
        m_pulse = 1'b0;
        if (sbtn != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = sbtn;
                m_run   = 0;
                m_pulse = sbtn;
            end
        end else begin
            m_run = 0;
        end
        if (we) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_pc  = (npc == WRAP) ? 32'h0 : npc;
        end
        m_pause_hist.push_back(sw_i[1]);
        if (m_pause_hist.size() > 2) void'(m_pause_hist.pop_front());
        m_btn_hist.push_back(step_btn);
        if (m_btn_hist.size() > 2) void'(m_btn_hist.pop_front());
        m_st = nst;
    endtask

    task automatic push_expected();
        exp_t e;
        e.we     = model_we();
        e.wrap   = e.we && (npc == WRAP);
        e.halted = (m_st == 1) || (m_st == 3);
        e.st     = 2'(m_st);
        e.cnt    = CW'(m_cnt);
        sb.push_back(e);
    endtask

    // One clock of stimulus. rst_on >= 0 asserts reset in the first cycle the
    // model reaches that state.
    task automatic cycle(input bit r, input bit p, input bit b, input int rst_on);
        bit r_eff;
        @(posedge clk);
        model_edge();
        r_eff = r;
        if (rst_on >= 0 && m_st == rst_on) begin
            r_eff     = 1'b1;
            rst_fired = 1'b1;
        end
        #1;
        rst = r_eff;
        if (r_eff) model_reset();
        sw_i     = 16'($urandom());
        sw_i[1]  = p;
        step_btn = b;
        pc       = m_pc;
        npc      = m_pc + 32'd4;
        push_expected();
    endtask

    task automatic run(input int n, input bit r, input bit p, input bit b);
        for (int i = 0; i < n; i++) cycle(r, p, b, -1);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_we", 32'(pc_we), 32'(e.we));
            chk("pc_wrap", 32'(pc_wrap), 32'(e.wrap));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("run_state", 32'(run_state), 32'(e.st));
            chk("retire_cnt", 32'(retire_cnt), 32'(e.cnt));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit p_lvl, b_lvl;
        int hold;
        rst      = 1'b1;
        sw_i     = 16'h0;
        step_btn = 1'b0;
        pc       = 32'h0;
        npc      = 32'h4;
        bp_addr  = 32'h0;
        bp_valid = 1'b0;
        model_reset();

        // Reset held, then free run through the 0x48 wrap point.
        run(3, 1'b1, 1'b0, 1'b0);
        run(25, 1'b0, 1'b0, 1'b0);

        // Pause, short glitch, long press, release, unpause.
        run(6, 1'b0, 1'b1, 1'b0);
        run(3, 1'b0, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b0);
        run(6, 1'b0, 1'b0, 1'b0);

        // Reset in the STEP cycle.
        rst_fired = 1'b0;
        for (int i = 0; i < 40 && !rst_fired; i++) cycle(1'b0, 1'b1, (i >= 4), 2);
        total++;
        if (!rst_fired) begin
            bad++;
            $display("FAIL reach_step: got no STEP want STEP within 40 cycles");
        end
        run(1, 1'b1, 1'b0, 1'b0);
        run(8, 1'b0, 1'b0, 1'b0);

`ifdef PC_BRKPT_EN
        // Breakpoint at 0x10, then one press out of BREAK.
        bp_valid = 1'b1;
        bp_addr  = 32'h10;
        run(2, 1'b1, 1'b0, 1'b0);
        run(8, 1'b0, 1'b0, 1'b0);
        run(8, 1'b0, 1'b0, 1'b1);
        run(8, 1'b0, 1'b0, 1'b0);

        // Reset while in BREAK.
        rst_fired = 1'b0;
        for (int i = 0; i < 60 && !rst_fired; i++) cycle(1'b0, 1'b0, 1'b0, 3);
        total++;
        if (!rst_fired) begin
            bad++;
            $display("FAIL reach_break: got no BREAK want BREAK within 60 cycles");
        end
        run(1, 1'b1, 1'b0, 1'b0);
        run(6, 1'b0, 1'b0, 1'b0);
        bp_valid = 1'b0;
`endif

        // Random phase.
        p_lvl = 1'b0;
        b_lvl = 1'b0;
        hold  = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) p_lvl = !p_lvl;
            if (hold == 0) begin
                b_lvl = !b_lvl;
                hold  = $urandom_range(1, 12);
            end
            hold--;
            if (HasBp && $urandom_range(0, 99) == 0) begin
                bp_valid = 1'($urandom_range(0, 1));
                bp_addr  = 32'($urandom_range(0, 18)) << 2;
            end
            cycle(($urandom_range(0, 399) == 0), p_lvl, b_lvl, -1);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
